// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: Hack ALU control encodings and sequencer FSM states
package alu_mul_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [5:0] ALU_ZERO = 6'b101010;
    localparam logic [5:0] ALU_ONE  = 6'b111111;
    localparam logic [5:0] ALU_NEG1 = 6'b111010;
    localparam logic [5:0] ALU_X    = 6'b001100;
    localparam logic [5:0] ALU_Y    = 6'b110000;
    localparam logic [5:0] ALU_NOTX = 6'b001101;
    localparam logic [5:0] ALU_NOTY = 6'b110001;
    localparam logic [5:0] ALU_NEGX = 6'b001111;
    localparam logic [5:0] ALU_NEGY = 6'b110011;
    localparam logic [5:0] ALU_XP1  = 6'b011111;
    localparam logic [5:0] ALU_YP1  = 6'b110111;
    localparam logic [5:0] ALU_XM1  = 6'b001110;
    localparam logic [5:0] ALU_YM1  = 6'b110010;
    localparam logic [5:0] ALU_ADD  = 6'b000010;
    localparam logic [5:0] ALU_XMY  = 6'b010011;
    localparam logic [5:0] ALU_YMX  = 6'b000111;
    localparam logic [5:0] ALU_AND  = 6'b000000;
    localparam logic [5:0] ALU_OR   = 6'b010101;
endpackage

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: operand/result handshake bundle of the multiplier sequencer
interface alu_mul_sequencer_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             res_zr;
    logic             res_ng;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result, res_zr, res_ng);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, result, res_zr, res_ng);
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 16x16->16 multiplier that borrows the shared Hack ALU for its additions
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_mul_sequencer_if.slave bus,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_out
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic             run, done, last;

    assign run  = state == RUN;
    assign done = state == DONE;
    // stop once no multiplier bits remain, or after the final bit position
    assign last = mplier[WIDTH-1:1] == '0 || cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (bus.out_ready ? IDLE : DONE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            acc    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            cnt    <= '0;
        end else if (run) begin
            if (mplier[0]) acc <= alu_out;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end

    // ALU-facing outputs sit at fixed reset values whenever the CPU owns the ALU
    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = done;
        bus.result    = done ? acc : '0;
        bus.res_zr    = done ? acc == '0 : 1'b1;
        bus.res_ng    = done & acc[WIDTH-1];
        alu_sel       = run;
        alu_x         = run ? acc : '0;
        alu_y         = run ? mcand : '0;
        alu_ctl       = run ? ALU_ADD : ALU_ZERO;
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed and randomized checks of the multiplier with a Hack ALU and operand muxes around it
module tb_alu_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_sel;
    logic [15:0] alu_x, alu_y, alu_out, ax, ay;
    logic [5:0]  alu_ctl, actl;
    logic [15:0] cpu_x = 16'h1357;
    logic [15:0] cpu_y = 16'h2468;
    logic [5:0]  cpu_ctl = 6'b011111;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.WIDTH(16)) bus ();

    alu_mul_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .alu_sel(alu_sel),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] x1, y1, o;
        x1 = c[5] ? 16'h0 : x;
        x1 = c[4] ? ~x1 : x1;
        y1 = c[3] ? 16'h0 : y;
        y1 = c[2] ? ~y1 : y1;
        o  = c[1] ? x1 + y1 : x1 & y1;
        return c[0] ? ~o : o;
    endfunction

    assign ax      = alu_sel ? alu_x : cpu_x;
    assign ay      = alu_sel ? alu_y : cpu_y;
    assign actl    = alu_sel ? alu_ctl : cpu_ctl;
    assign alu_out = hack_alu(ax, ay, actl);

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, output int runc);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin w++; @(negedge clk); end
        bus.in_valid = 1'b1; bus.a = av; bus.b = bv;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF;
        runc = 0;
        while (alu_sel && runc < 40) begin runc++; @(negedge clk); end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nvec += 9;
        if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
        if (bus.result !== 16'h0) begin nerr++; $display("FAIL reset result got %h want 0000", bus.result); end
        if (bus.res_zr !== 1'b1) begin nerr++; $display("FAIL reset res_zr got %b want 1", bus.res_zr); end
        if (bus.res_ng !== 1'b0) begin nerr++; $display("FAIL reset res_ng got %b want 0", bus.res_ng); end
        if (alu_sel !== 1'b0) begin nerr++; $display("FAIL reset alu_sel got %b want 0", alu_sel); end
        if (alu_x !== 16'h0) begin nerr++; $display("FAIL reset alu_x got %h want 0000", alu_x); end
        if (alu_y !== 16'h0) begin nerr++; $display("FAIL reset alu_y got %h want 0000", alu_y); end
        if (alu_ctl !== 6'b101010) begin nerr++; $display("FAIL reset alu_ctl got %b want 101010", alu_ctl); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int runc;
        do_op(16'd3, 16'd5, runc);
        nvec += 5;
        if (runc !== 3) begin nerr++; $display("FAIL basic run_cycles got %0d want 3", runc); end
        if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL basic out_valid got %b want 1", bus.out_valid); end
        if (bus.result !== 16'h000F) begin nerr++; $display("FAIL basic result got %h want 000f", bus.result); end
        if (bus.res_zr !== 1'b0) begin nerr++; $display("FAIL basic res_zr got %b want 0", bus.res_zr); end
        if (bus.res_ng !== 1'b0) begin nerr++; $display("FAIL basic res_ng got %b want 0", bus.res_ng); end
        take();
        do_op(16'hFFFF, 16'hFFFF, runc);
        nvec += 2;
        if (runc !== 16) begin nerr++; $display("FAIL neg run_cycles got %0d want 16", runc); end
        if (bus.result !== 16'h0001) begin nerr++; $display("FAIL neg result got %h want 0001", bus.result); end
        take();
    endtask

    task automatic test_bounds();
        logic [15:0] av [4] = '{16'h1234, 16'h0007, 16'h0000, 16'h0100};
        logic [15:0] bv [4] = '{16'h0000, 16'h8000, 16'h00F0, 16'h0100};
        logic [15:0] ev [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000};
        int          rv [4] = '{1, 16, 8, 9};
        logic        zv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        nv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int runc;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], runc);
            nvec += 4;
            if (runc !== rv[i]) begin nerr++; $display("FAIL bounds[%0d] run_cycles got %0d want %0d", i, runc, rv[i]); end
            if (bus.result !== ev[i]) begin nerr++; $display("FAIL bounds[%0d] result got %h want %h", i, bus.result, ev[i]); end
            if (bus.res_zr !== zv[i]) begin nerr++; $display("FAIL bounds[%0d] res_zr got %b want %b", i, bus.res_zr, zv[i]); end
            if (bus.res_ng !== nv[i]) begin nerr++; $display("FAIL bounds[%0d] res_ng got %b want %b", i, bus.res_ng, nv[i]); end
            take();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [4] = '{16'h00FF, 16'h8000, 16'hFFFE, 16'h1111};
        logic [15:0] bv [4] = '{16'h0101, 16'h0002, 16'h0003, 16'h000F};
        logic [15:0] ev [4] = '{16'hFFFF, 16'h0000, 16'hFFFA, 16'hFFFF};
        int          rv [4] = '{9, 2, 2, 4};
        int runc;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], runc);
            nvec += 2;
            if (runc !== rv[i]) begin nerr++; $display("FAIL b2b[%0d] run_cycles got %0d want %0d", i, runc, rv[i]); end
            if (bus.result !== ev[i]) begin nerr++; $display("FAIL b2b[%0d] result got %h want %h", i, bus.result, ev[i]); end
            take();
        end
    endtask

    task automatic test_backpressure();
        int runc;
        do_op(16'h0012, 16'h0034, runc);
        nvec++;
        if (runc !== 6) begin nerr++; $display("FAIL bp run_cycles got %0d want 6", runc); end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0003;
            nvec += 3;
            if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL bp[%0d] out_valid got %b want 1", i, bus.out_valid); end
            if (bus.result !== 16'h03A8) begin nerr++; $display("FAIL bp[%0d] result got %h want 03a8", i, bus.result); end
            if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL bp[%0d] in_ready got %b want 0", i, bus.in_ready); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        take();
        nvec += 3;
        if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp idle in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bp idle out_valid got %b want 0", bus.out_valid); end
        if (alu_sel !== 1'b0) begin nerr++; $display("FAIL bp idle alu_sel got %b want 0", alu_sel); end
    endtask

    task automatic test_async_reset();
        int runc;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 16'd9; bus.b = 16'h00FF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if (alu_sel !== 1'b1) begin nerr++; $display("FAIL arst run4 alu_sel got %b want 1", alu_sel); end
        #2 rst_n = 1'b0;
        #1;
        nvec += 6;
        if (alu_sel !== 1'b0) begin nerr++; $display("FAIL arst alu_sel got %b want 0", alu_sel); end
        if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL arst in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL arst out_valid got %b want 0", bus.out_valid); end
        if (alu_x !== 16'h0) begin nerr++; $display("FAIL arst alu_x got %h want 0000", alu_x); end
        if (alu_y !== 16'h0) begin nerr++; $display("FAIL arst alu_y got %h want 0000", alu_y); end
        if (alu_ctl !== 6'b101010) begin nerr++; $display("FAIL arst alu_ctl got %b want 101010", alu_ctl); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'd2, 16'd3, runc);
        nvec += 2;
        if (runc !== 2) begin nerr++; $display("FAIL arst next run_cycles got %0d want 2", runc); end
        if (bus.result !== 16'h0006) begin nerr++; $display("FAIL arst next result got %h want 0006", bus.result); end
        take();
    endtask

    task automatic test_random();
        logic [15:0] av, bv, ev;
        int runc, erun;
        for (int i = 0; i < 1000; i++) begin
            av = 16'($urandom);
            bv = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            ev = av * bv;
            erun = 1;
            for (int k = 0; k < 16; k++) if (bv[k]) erun = k + 1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(av, bv, runc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            nvec += 2;
            if (runc !== erun) begin nerr++; $display("FAIL rand[%0d] run_cycles got %0d want %0d", i, runc, erun); end
            if (bus.result !== ev) begin nerr++; $display("FAIL rand[%0d] %h*%h result got %h want %h", i, av, bv, bus.result, ev); end
            take();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_bounds();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
